// File: rtl/parking_display_scan_pkg.sv
// Shared encodings and types for the parking-lot free-space display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package parking_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        CNV_IDLE,
        CNV_SHIFT,
        CNV_DONE
    } cnv_state_e;

    typedef struct packed {
        logic [3:0] hund;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd3_t;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3).
// IDLE -> SHIFT (8 cycles) -> DONE -> IDLE; result valid on bcd while done=1.
module bin2bcd_seq
    import parking_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] din,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output bcd3_t      bcd
);

    cnv_state_e  state, state_next;
    logic [19:0] shreg;
    logic [19:0] shreg_adj;
    logic [2:0]  bit_cnt;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // {hundreds, tens, ones, binary}; binary bits shift into the ones nibble
    always_comb begin
        shreg_adj = {add3(shreg[19:16]), add3(shreg[15:12]), add3(shreg[11:8]), shreg[7:0]};
    end

    assign bcd = shreg[19:8];

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        unique case (state)
            CNV_IDLE: begin
                ready = 1'b1;
                if (start) state_next = CNV_SHIFT;
            end
            CNV_SHIFT: begin
                if (bit_cnt == 3'd7) state_next = CNV_DONE;
            end
            CNV_DONE: begin
                done       = 1'b1;
                state_next = CNV_IDLE;
            end
            default: state_next = CNV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= CNV_IDLE;
        else        state <= state_next;
    end

    // busy is registered: rises with the start edge and falls with the DONE edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                CNV_IDLE: begin
                    if (start) begin
                        shreg   <= {12'd0, din};
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                CNV_SHIFT: begin
                    shreg   <= {shreg_adj[18:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                CNV_DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/parking_display_scan.sv
// 4-digit multiplexed 7-segment driver showing "P nnn" or "F  0" free spaces.
// Optional FULL_BLINK_EN: blinks the display while the lot is full.
module parking_display_scan
    import parking_pkg::*;
#(
    parameter int CAPACITY    = 150,
    parameter int BLINK_TICKS = 500
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_clk,
    input  logic [7:0] free_count,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       busy
);

    localparam logic [7:0] CAP8 = 8'(CAPACITY);

    logic [7:0] clamped;
    logic [7:0] last_value;
    logic       pending;
    logic       start_req;
    logic       cnv_ready;
    logic       cnv_done;
    bcd3_t      cnv_bcd;
    bcd3_t      disp_buf;

    assign clamped   = (free_count > CAP8) ? CAP8 : free_count;
    assign start_req = pending || (clamped != last_value);

    // pending forces one conversion after every reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= 1'b1;
            last_value <= '0;
        end else if (cnv_ready && start_req) begin
            pending    <= 1'b0;
            last_value <= clamped;
        end
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (start_req),
        .din   (clamped),
        .ready (cnv_ready),
        .busy  (busy),
        .done  (cnv_done),
        .bcd   (cnv_bcd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        disp_buf <= '0;
        else if (cnv_done) disp_buf <= cnv_bcd;
    end

    // scan_clk is asynchronous data: 2-FF sync, then registered rising-edge pulse
    logic [1:0] scan_sync;
    logic       scan_prev;
    logic       tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_sync <= '0;
            scan_prev <= 1'b0;
            tick      <= 1'b0;
        end else begin
            scan_sync <= {scan_sync[0], scan_clk};
            scan_prev <= scan_sync[1];
            tick      <= scan_sync[1] & ~scan_prev;
        end
    end

    logic       value_zero;
    logic       blank_an;
    logic [1:0] idx;
    logic [6:0] digit_seg;

    assign value_zero = (disp_buf == '0);

`ifdef FULL_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blank_an = value_zero & blink_phase;
`else
    assign blank_an = 1'b0;
`endif

    always_comb begin
        digit_seg = SEG_BLANK;
        unique case (idx)
            2'd0: digit_seg = seg_digit(disp_buf.ones);
            2'd1: digit_seg = (disp_buf.hund == 4'd0 && disp_buf.tens == 4'd0)
                              ? SEG_BLANK : seg_digit(disp_buf.tens);
            2'd2: digit_seg = (disp_buf.hund == 4'd0) ? SEG_BLANK : seg_digit(disp_buf.hund);
            2'd3: digit_seg = value_zero ? SEG_F : SEG_P;
            default: digit_seg = SEG_BLANK;
        endcase
    end

    // an/seg change only on a tick, so a buffer update waits for the next tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
            an  <= 4'hF;
            seg <= SEG_BLANK;
        end else if (tick) begin
            idx <= idx + 2'd1;
            an  <= blank_an ? 4'hF : ~(4'b0001 << idx);
            seg <= digit_seg;
        end
    end

endmodule

// File: tb/tb_parking_display_scan.sv
// Directed self-checking bench for parking_display_scan (BLINK_TICKS overridden to 4).
module tb_parking_display_scan;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scan_clk = 1'b0;
    logic [7:0] free_count = 8'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       busy;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] exp_idx = 2'd0;
    logic [3:0] one4 = 4'b0001;

    parking_display_scan #(.CAPACITY(150), .BLINK_TICKS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_clk   (scan_clk),
        .free_count (free_count),
        .an         (an),
        .seg        (seg),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // one scan_clk period; outputs sampled well after the 3+1 clk latency
    task automatic pulse_scan(output logic [3:0] a, output logic [6:0] s);
        scan_clk = 1'b1;
        repeat (6) @(negedge clk);
        a = an;
        s = seg;
        scan_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic scan_all(output logic [3:0][6:0] d);
        logic [3:0] a;
        logic [6:0] s;
        for (int k = 0; k < 4; k++) begin
            pulse_scan(a, s);
            d[exp_idx] = s;
            exp_idx = exp_idx + 2'd1;
        end
    endtask

    task automatic test_display(input string name, input logic [7:0] v, input logic [3:0][6:0] e);
        logic [3:0][6:0] d;
        free_count = v;
        repeat (15) @(negedge clk);
        scan_all(d);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (d[k] !== e[k]) begin
                n_bad++;
                $display("FAIL %s digit%0d got %h want %h", name, k, d[k], e[k]);
            end
        end
    endtask

    task automatic test_reset;
        logic [3:0][6:0] d;
        logic [3:0][6:0] e;
        reset = 1'b0;
        free_count = 8'd0;
        repeat (5) @(negedge clk);
        n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL reset_an got %h want f", an); end
        n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got %h want 7f", seg); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b1;
        exp_idx = 2'd0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_request got busy=%b want 1", busy); end
        repeat (12) @(negedge clk);
        e = {7'h0E, 7'h7F, 7'h7F, 7'h40};
        scan_all(d);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (d[k] !== e[k]) begin
                n_bad++;
                $display("FAIL reset_zero digit%0d got %h want %h", k, d[k], e[k]);
            end
        end
    endtask

    task automatic test_busy_123;
        int cnt = 0;
        free_count = 8'd123;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy === 1'b1) cnt++;
        end
        n_cmp++; if (cnt != 9) begin n_bad++; $display("FAIL busy_len got %0d want 9", cnt); end
        test_display("val123", 8'd123, {7'h0C, 7'h79, 7'h24, 7'h30});
    endtask

    task automatic test_blank_clamp;
        test_display("val7",   8'd7,   {7'h0C, 7'h7F, 7'h7F, 7'h78});
        test_display("clamp200", 8'd200, {7'h0C, 7'h79, 7'h12, 7'h40});
        test_display("val100", 8'd100, {7'h0C, 7'h79, 7'h40, 7'h40});
        test_display("val10",  8'd10,  {7'h0C, 7'h7F, 7'h79, 7'h40});
        test_display("clamp151", 8'd151, {7'h0C, 7'h79, 7'h12, 7'h40});
    endtask

    task automatic test_change_mid;
        logic [3:0]      a;
        logic [6:0]      s;
        logic [3:0][6:0] e45;
        int              n = 0;
        while (exp_idx != 2'd0) begin
            pulse_scan(a, s);
            exp_idx = exp_idx + 2'd1;
        end
        e45 = {7'h0C, 7'h7F, 7'h19, 7'h12};
        free_count = 8'd45;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b want 1", busy); end
        free_count = 8'd46;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); n++;
            if (busy === 1'b0) break;
        end
        scan_clk = 1'b1;
        repeat (6) @(negedge clk);
        n += 6;
        n_cmp++;
        if (seg !== e45[exp_idx]) begin
            n_bad++; $display("FAIL mid_first got %h want %h", seg, e45[exp_idx]);
        end
        exp_idx = exp_idx + 2'd1;
        scan_clk = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk); n++;
        end
        n_cmp++; if (n > 21) begin n_bad++; $display("FAIL mid_latency got %0d clk want <=21", n); end
        test_display("mid_second", 8'd46, {7'h0C, 7'h7F, 7'h19, 7'h02});
    endtask

    task automatic test_scan;
        logic [3:0] a;
        logic [6:0] s;
        logic [3:0] ea;
        for (int k = 0; k < 5; k++) begin
            ea = ~(one4 << exp_idx);
            pulse_scan(a, s);
            exp_idx = exp_idx + 2'd1;
            n_cmp++;
            if (a !== ea) begin n_bad++; $display("FAIL scan_an%0d got %h want %h", k, a, ea); end
        end
        ea = ~(one4 << (exp_idx - 2'd1));
        repeat (20) @(negedge clk);
        n_cmp++; if (an !== ea) begin n_bad++; $display("FAIL scan_idle got %h want %h", an, ea); end
        ea = ~(one4 << exp_idx);
        scan_clk = 1'b1;
        repeat (30) @(negedge clk);
        exp_idx = exp_idx + 2'd1;
        n_cmp++; if (an !== ea) begin n_bad++; $display("FAIL scan_held got %h want %h", an, ea); end
        scan_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        free_count = 8'd99;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy got %b want 1", busy); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_clear got %b want 0", busy); end
        n_cmp++; if (an !== 4'hF) begin n_bad++; $display("FAIL rmid_an got %h want f", an); end
        reset = 1'b1;
        exp_idx = 2'd0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_restart got %b want 1", busy); end
        test_display("rmid_val99", 8'd99, {7'h0C, 7'h7F, 7'h10, 7'h10});
    endtask

    task automatic test_blink;
        logic [3:0] a;
        logic [6:0] s;
        logic [3:0] ea;
        reset = 1'b0;
        free_count = 8'd0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        exp_idx = 2'd0;
        repeat (15) @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            ea = ~(one4 << exp_idx);
`ifdef FULL_BLINK_EN
            if (k >= 5) ea = 4'hF;
`endif
            pulse_scan(a, s);
            exp_idx = exp_idx + 2'd1;
            n_cmp++;
            if (a !== ea) begin n_bad++; $display("FAIL blink_tick%0d got %h want %h", k, a, ea); end
        end
    endtask

    initial begin
        test_reset();
        test_busy_123();
        test_blank_clamp();
        test_change_mid();
        test_scan();
        test_reset_mid();
        test_blink();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
